// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (CPU / debug) arbiter for a single-port data RAM.
//               The CPU has priority. A starving debug port is forced through
//               after MAX_WAIT lost cycles and then owns the RAM for up to
//               BURST_LEN beats. While halt is high, debug has unconditional
//               priority. Read data returns one cycle after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int MAX_WAIT  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [BEAT_W-1:0] c_beat_max = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] c_beat_one = BEAT_W'(1);
  localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MAX_WAIT);

  localparam logic [0:0] ST_CPU = 1'b0;
  localparam logic [0:0] ST_DBG = 1'b1;

  logic [0:0]        r_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_cpu_rd_pend;
  logic              r_dbg_rd_pend;

  logic              w_cpu_gnt;
  logic              w_dbg_gnt;
  logic              w_burst_cont;
  logic [WAIT_W-1:0] w_wait_eff;

  // Grant decision: continue an owned debug burst, otherwise CPU-priority
  // arbitration (a burst that ends falls back to it in the same cycle with
  // the starvation counter seen as zero).
  always_comb begin
    w_cpu_gnt    = 1'b0;
    w_dbg_gnt    = 1'b0;
    w_burst_cont = 1'b0;
    w_wait_eff   = (r_state == ST_CPU) ? r_wait_cnt : '0;
    if ((r_state == ST_DBG) && dbg_req && ((r_beat_cnt < c_beat_max) || halt)) begin
      w_dbg_gnt    = 1'b1;
      w_burst_cont = 1'b1;
    end else begin
      w_dbg_gnt = dbg_req & (halt | ~cpu_req | (w_wait_eff == c_wait_max));
      w_cpu_gnt = cpu_req & ~w_dbg_gnt;
    end
    if (reset) begin
      w_cpu_gnt    = 1'b0;
      w_dbg_gnt    = 1'b0;
      w_burst_cont = 1'b0;
    end
  end

  // Arbiter state, counters, held address and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_CPU;
      r_beat_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_last_addr   <= '0;
      r_cpu_rd_pend <= 1'b0;
      r_dbg_rd_pend <= 1'b0;
    end else begin
      if (w_dbg_gnt) begin
        r_state <= ST_DBG;
        if (!w_burst_cont) begin
          r_beat_cnt <= c_beat_one;
        end else if (r_beat_cnt != c_beat_max) begin
          r_beat_cnt <= r_beat_cnt + c_beat_one;
        end
      end else begin
        r_state    <= ST_CPU;
        r_beat_cnt <= '0;
      end

      if (dbg_req && !w_dbg_gnt) begin
        r_wait_cnt <= (w_wait_eff == c_wait_max) ? c_wait_max : w_wait_eff + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_dbg_gnt) begin
        r_last_addr <= dbg_addr;
      end else if (w_cpu_gnt) begin
        r_last_addr <= cpu_addr;
      end

      r_cpu_rd_pend <= w_cpu_gnt & ~cpu_we;
      r_dbg_rd_pend <= w_dbg_gnt & ~dbg_we;
    end
  end

  // RAM-side mux; the address is parked on the last granted one when idle.
  always_comb begin
    mem_addr  = r_last_addr;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (reset) begin
      mem_addr = '0;
    end else if (w_dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wren  = dbg_we;
    end else if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wren  = cpu_we;
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign cpu_stall  = cpu_req & ~w_cpu_gnt & ~reset;
  // A read issued just before reset must not surface during or after it.
  assign cpu_rvalid = r_cpu_rd_pend & ~reset;
  assign dbg_rvalid = r_dbg_rd_pend & ~reset;
  assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed vector bench for mem_arbiter (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] mem_q = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset), .halt(halt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  typedef struct {
    bit        rst, hlt, creq, cwe, dreq, dwe;
    bit [7:0]  caddr, daddr;
    bit [31:0] cwd, dwd;
    bit        cg, cs, crv, dg, drv, ewren;
    bit [7:0]  eaddr;
    bit [31:0] ewd;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rst, bit hlt, bit creq, bit cwe, bit [7:0] caddr, bit [31:0] cwd,
                              bit dreq, bit dwe, bit [7:0] daddr, bit [31:0] dwd,
                              bit cg, bit cs, bit crv, bit dg, bit drv,
                              bit [7:0] eaddr, bit [31:0] ewd, bit ewren);
    vec_t v;
    v.rst = rst; v.hlt = hlt; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.cg = cg; v.cs = cs; v.crv = crv; v.dg = dg; v.drv = drv;
    v.eaddr = eaddr; v.ewd = ewd; v.ewren = ewren;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    int ncpu;
    int ndbg;
    bit seen;

    // reset overrides requests
    add(1,0, 1,0,8'h05,0, 1,0,8'h09,0,  0,0,0,0,0, 8'h00,0,0);
    add(1,0, 1,0,8'h05,0, 1,0,8'h09,0,  0,0,0,0,0, 8'h00,0,0);
    // CPU-only reads of 0x05, then idle
    add(0,0, 1,0,8'h05,0, 0,0,0,0,      1,0,0,0,0, 8'h05,0,0);
    add(0,0, 1,0,8'h05,0, 0,0,0,0,      1,0,1,0,0, 8'h05,0,0);
    add(0,0, 1,0,8'h05,0, 0,0,0,0,      1,0,1,0,0, 8'h05,0,0);
    add(0,0, 0,0,0,0,     0,0,0,0,      0,0,1,0,0, 8'h05,0,0);
    add(0,0, 0,0,0,0,     0,0,0,0,      0,0,0,0,0, 8'h05,0,0);
    // CPU write, then idle holds its address
    add(0,0, 1,1,8'h10,32'h12345678, 0,0,0,0, 1,0,0,0,0, 8'h10,32'h12345678,1);
    add(0,0, 0,0,0,0,     0,0,0,0,      0,0,0,0,0, 8'h10,0,0);
    // contention: 3 CPU, forced debug, 4 debug beats, CPU again
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  1,0,0,0,0, 8'h20,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  1,0,1,0,0, 8'h20,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  1,0,1,0,0, 8'h20,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  0,1,1,1,0, 8'h40,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  0,1,0,1,1, 8'h40,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  0,1,0,1,1, 8'h40,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  0,1,0,1,1, 8'h40,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  1,0,0,0,1, 8'h20,0,0);
    add(0,0, 1,0,8'h20,0, 1,0,8'h40,0,  1,0,1,0,0, 8'h20,0,0);
    add(0,0, 0,0,0,0,     0,0,0,0,      0,0,1,0,0, 8'h20,0,0);
    // halted: 8-word debug write burst, CPU stalled throughout
    for (int k = 0; k < 8; k++)
      add(0,1, 1,0,8'h30,0, 1,1,8'(k),32'hD0 + k, 0,1,0,1,0, 8'(k),32'hD0 + k,1);
    // halt drops after 8 beats: burst limit hits at once, CPU wins
    add(0,0, 1,0,8'h30,0, 1,1,8'h08,32'hD8, 1,0,0,0,0, 8'h30,0,0);
    add(0,0, 1,0,8'h30,0, 0,0,0,0,      1,0,1,0,0, 8'h30,0,0);
    // halt rises mid CPU stream: debug takes over that cycle
    add(0,1, 1,0,8'h30,0, 1,0,8'h50,0,  0,1,1,1,0, 8'h50,0,0);
    add(0,0, 1,0,8'h30,0, 0,0,0,0,      1,0,0,0,1, 8'h30,0,0);
    // debug read granted, then reset: no rvalid, CPU granted right after
    add(0,0, 0,0,0,0,     1,0,8'h60,0,  0,0,1,1,0, 8'h60,0,0);
    add(1,0, 1,0,8'h70,0, 1,0,8'h61,0,  0,0,0,0,0, 8'h00,0,0);
    add(0,0, 1,0,8'h70,0, 1,0,8'h61,0,  1,0,0,0,0, 8'h70,0,0);
    add(0,0, 0,0,0,0,     0,0,0,0,      0,0,1,0,0, 8'h70,0,0);
    // halt drops after beat 1: burst still capped at 4 beats total
    add(0,1, 1,0,8'h71,0, 1,0,8'h80,0,  0,1,0,1,0, 8'h80,0,0);
    add(0,0, 1,0,8'h71,0, 1,0,8'h80,0,  0,1,0,1,1, 8'h80,0,0);
    add(0,0, 1,0,8'h71,0, 1,0,8'h80,0,  0,1,0,1,1, 8'h80,0,0);
    add(0,0, 1,0,8'h71,0, 1,0,8'h80,0,  0,1,0,1,1, 8'h80,0,0);
    add(0,0, 1,0,8'h71,0, 1,0,8'h80,0,  1,0,0,0,1, 8'h71,0,0);
    add(0,0, 0,0,0,0,     0,0,0,0,      0,0,1,0,0, 8'h71,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst; halt = vq[i].hlt;
      cpu_req = vq[i].creq; cpu_we = vq[i].cwe; cpu_addr = vq[i].caddr; cpu_wdata = vq[i].cwd;
      dbg_req = vq[i].dreq; dbg_we = vq[i].dwe; dbg_addr = vq[i].daddr; dbg_wdata = vq[i].dwd;
      mem_q = 32'hA000_0000 + 32'(i);
      #1;
      chk("cpu_gnt",    i, 32'(cpu_gnt),    32'(vq[i].cg));
      chk("cpu_stall",  i, 32'(cpu_stall),  32'(vq[i].cs));
      chk("cpu_rvalid", i, 32'(cpu_rvalid), 32'(vq[i].crv));
      chk("cpu_rdata",  i, cpu_rdata,       vq[i].crv ? 32'hA000_0000 + 32'(i) : 32'h0);
      chk("dbg_gnt",    i, 32'(dbg_gnt),    32'(vq[i].dg));
      chk("dbg_rvalid", i, 32'(dbg_rvalid), 32'(vq[i].drv));
      chk("dbg_rdata",  i, dbg_rdata,       vq[i].drv ? 32'hA000_0000 + 32'(i) : 32'h0);
      chk("mem_addr",   i, 32'(mem_addr),   32'(vq[i].eaddr));
      chk("mem_wdata",  i, mem_wdata,       vq[i].ewd);
      chk("mem_wren",   i, 32'(mem_wren),   32'(vq[i].ewren));
      chk("no_overlap", i, 32'(cpu_gnt & dbg_gnt), 32'h0);
    end

    // Free-running contention after reset, with bounded waits.
    @(negedge clk);
    reset = 1'b1; halt = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h11;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h22;
    ncpu = 0; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      chk("seq_overlap", k, 32'(cpu_gnt & dbg_gnt), 32'h0);
      if (dbg_gnt) seen = 1'b1;
      else if (cpu_gnt) ncpu++;
      @(negedge clk);
    end
    chk("seq_dbg_forced_seen", 0, 32'(seen), 32'h1);
    chk("seq_cpu_before_force", 0, 32'(ncpu), 32'd3);
    ndbg = 1; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      chk("seq_overlap", 100 + k, 32'(cpu_gnt & dbg_gnt), 32'h0);
      if (cpu_gnt) seen = 1'b1;
      else if (dbg_gnt) ndbg++;
      @(negedge clk);
    end
    chk("seq_cpu_regained", 0, 32'(seen), 32'h1);
    chk("seq_dbg_beats", 0, 32'(ndbg), 32'd4);

    cpu_req = 1'b0; dbg_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, word address width of the data RAM.
REQ-002 The module SHALL have parameter DATA_W, default 32, data word width.
REQ-003 The module SHALL have parameter BURST_LEN, default 4, maximum consecutive debug grants before the CPU regains priority.
REQ-004 The module SHALL have parameter MAX_WAIT, default 3, number of consecutive lost debug cycles after which debug is forced a grant.
REQ-005 The module SHALL have one clock; reset is synchronous and active-high.
REQ-006 The module SHALL have these ports, as name  direction  width  meaning:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- halt  in  1  CPU halted; debug port has unconditional priority
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write enable (valid with cpu_req)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req  in  1  debug/loader access request
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug access issued this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data, 1-cycle latency after address

Function
REQ-007 Grants SHALL be combinational from current state and requests; cpu_gnt and dbg_gnt SHALL never both be 1; a grant SHALL only be given to a requesting port.
REQ-008 The FSM SHALL have states ST_CPU (CPU priority) and ST_DBG (debug burst owner), plus a beat_cnt counter (0..BURST_LEN) and a wait_cnt counter (0..MAX_WAIT, saturating).
REQ-009 In ST_CPU: dbg_gnt = dbg_req & (halt | ~cpu_req | wait_cnt==MAX_WAIT); otherwise cpu_gnt = cpu_req; a debug grant SHALL move to ST_DBG with beat_cnt=1.
REQ-010 wait_cnt SHALL increment when dbg_req=1 and dbg_gnt=0, and clear when dbg_gnt=1 or dbg_req=0.
REQ-011 In ST_DBG with dbg_req=1 and (beat_cnt<BURST_LEN or halt=1): grant debug; beat_cnt increments, saturating at BURST_LEN.
REQ-012 In ST_DBG with dbg_req=0 or beat_cnt==BURST_LEN (halt=0): go to ST_CPU and arbitrate the same cycle per REQ-009, with wait_cnt treated as 0.
REQ-013 The granted port's addr/wdata/we SHALL drive mem_addr/mem_wdata/mem_wren the same cycle; with no grant, mem_wren=0, mem_wdata=0, mem_addr holds the last granted address.
REQ-014 A granted read (gnt & ~we) SHALL produce <port>_rvalid=1 exactly one cycle later, with <port>_rdata=mem_q that cycle; otherwise rvalid=0 and rdata=0.
REQ-015 Granted writes SHALL produce no rvalid; back-to-back reads SHALL yield one rvalid per cycle in order.
REQ-016 halt rising mid-CPU-stream SHALL take effect the same cycle; halt falling in ST_DBG SHALL apply the BURST_LEN limit from the current beat_cnt.

Reset
REQ-017 While reset=1, state SHALL be ST_CPU, beat_cnt=0, wait_cnt=0, and both grants, both rvalids, mem_wren, cpu_stall, all rdata, mem_wdata and mem_addr SHALL be 0; reset overrides all requests.
REQ-018 A read granted in the cycle before reset SHALL NOT produce rvalid after reset; a burst in progress SHALL be aborted.

Verification
REQ-019 CPU only: cpu_req=1, we=0, addr=0x05 for 3 cycles -> cpu_gnt=1 each cycle, cpu_rvalid=1 cycles 2..4 with mem_q values, cpu_stall=0.
REQ-020 Contention, halt=0, both requesting continuously -> CPU granted 3 cycles, debug forced on 4th (wait_cnt=3), then 4 debug beats, then CPU again; grants never overlap.
REQ-021 halt=1, dbg write burst of 8 words addr 0x00..0x07 -> 8 consecutive dbg_gnt with mem_wren=1, no BURST_LEN break, cpu_stall=1 throughout if cpu_req=1.
REQ-022 Idle: no requests -> mem_wren=0, mem_addr holds last value, no rvalid.
REQ-023 Reset asserted the cycle after a dbg read grant -> dbg_rvalid stays 0, state ST_CPU, first post-reset cpu_req granted immediately.
